// File: rtl/mul_approx_pkg.sv
// Shared helpers for the truncated (broken-array) multiplier: trunc saturation,
// column-enable mask generation and the maximum-width stage payload view.
package mul_approx_pkg;

  localparam int unsigned PW_MAX = 64;
  localparam int unsigned OW_MAX = 32;
  localparam int unsigned TW_MAX = 8;

  // Widest stage payload; concrete stages carry only the fields their phase needs.
  typedef struct packed {
    logic              valid;
    logic [OW_MAX-1:0] a;
    logic [OW_MAX-1:0] b;
    logic [TW_MAX-1:0] trunc;
    logic [PW_MAX-1:0] psum_lo;
    logic [PW_MAX-1:0] psum_hi;
  } stage_payload_t;

  function automatic int unsigned trunc_sat(input int unsigned t, input int unsigned w);
    return (t > 2 * w - 1) ? 2 * w - 1 : t;
  endfunction

  // Column c of the 2w-bit product survives only when c >= t.
  function automatic logic [PW_MAX-1:0] col_mask(input int unsigned t, input int unsigned w);
    logic [PW_MAX-1:0] m;
    m = '0;
    for (int unsigned c = 0; c < PW_MAX; c++) begin
      m[c] = (c >= t) && (c < 2 * w);
    end
    return m;
  endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// Single valid/ready register slice, generic in payload width.
// The slice accepts new data whenever it is empty or its content is leaving.
module mul_pipe_stage #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready_c,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  assign in_ready_c = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_ready_c) begin
        out_valid <= in_valid;
      end
      if (in_valid && in_ready_c) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mul_trunc_pipe.sv
// Pipelined unsigned approximate multiplier: partial products below the
// per-beat truncation column are dropped; trunc=0 yields the exact product.
module mul_trunc_pipe
  import mul_approx_pkg::*;
#(
  parameter int unsigned W      = 12,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TW     = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [TW-1:0]   in_trunc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_p,
  output logic [TW-1:0]   out_trunc,
  output logic            busy
);

  localparam int unsigned PW   = 2 * W;
  localparam int unsigned WW   = TW + 2 * PW;
  localparam int unsigned NW   = TW + PW;
  localparam int unsigned NF   = (STAGES >= 3) ? 2 : STAGES - 1;
  localparam int unsigned NN   = STAGES - NF;
  localparam int unsigned HALF = W / 2;

  // Sum of rows j in [lo, hi), each row restricted to the enabled columns.
  function automatic logic [PW-1:0] row_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [PW-1:0] m, input int unsigned lo,
                                            input int unsigned hi);
    logic [PW-1:0] acc;
    acc = '0;
    for (int unsigned j = 0; j < W; j++) begin
      if (j >= lo && j < hi && b[j]) begin
        acc = acc + ((PW'(a) << j) & m);
      end
    end
    return acc;
  endfunction

  logic [TW-1:0]   t_in;
  logic [PW-1:0]   m_in;
  logic [STAGES-1:0] stage_vld;

  logic            nv [0:NN];
  logic            nr [0:NN];
  logic [NW-1:0]   nd [0:NN];

  assign t_in = TW'(trunc_sat(32'(in_trunc), W));
  assign m_in = PW'(col_mask(32'(t_in), W));

  generate
    if (NF == 0) begin : g_front_comb
      // Single stage: the whole reduction lands in one register.
      assign nd[0]    = {t_in, row_sum(in_a, in_b, m_in, 0, W)};
      assign nv[0]    = in_valid;
      assign in_ready = nr[0];
    end else begin : g_front
      logic          v0;
      logic          r0;
      logic [WW-1:0] d0;
      logic [TW-1:0] t0;
      logic [PW-1:0] m0;
      logic [W-1:0]  a0;
      logic [W-1:0]  b0;

      mul_pipe_stage #(.PW(WW)) u_s0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready_c (in_ready),
        .in_data    ({t_in, m_in, in_a, in_b}),
        .out_valid  (v0),
        .out_ready  (r0),
        .out_data   (d0)
      );

      assign stage_vld[0] = v0;
      assign t0 = d0[WW-1 -: TW];
      assign m0 = d0[2*PW-1 -: PW];
      assign a0 = d0[PW-1 -: W];
      assign b0 = d0[W-1:0];

      if (NF == 1) begin : g_one
        assign nd[0] = {t0, row_sum(a0, b0, m0, 0, W)};
        assign nv[0] = v0;
        assign r0    = nr[0];
      end else begin : g_two
        logic          v1;
        logic [WW-1:0] d1;

        // Lower and upper row halves reduced in parallel, combined one stage later.
        mul_pipe_stage #(.PW(WW)) u_s1 (
          .clk        (clk),
          .rst_n      (rst_n),
          .in_valid   (v0),
          .in_ready_c (r0),
          .in_data    ({t0, row_sum(a0, b0, m0, 0, HALF), row_sum(a0, b0, m0, HALF, W)}),
          .out_valid  (v1),
          .out_ready  (nr[0]),
          .out_data   (d1)
        );

        assign stage_vld[1] = v1;
        assign nd[0] = {d1[WW-1 -: TW], d1[2*PW-1 -: PW] + d1[PW-1:0]};
        assign nv[0] = v1;
      end
    end

    for (genvar k = 0; k < NN; k++) begin : g_tail
      mul_pipe_stage #(.PW(NW)) u_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (nv[k]),
        .in_ready_c (nr[k]),
        .in_data    (nd[k]),
        .out_valid  (nv[k+1]),
        .out_ready  (nr[k+1]),
        .out_data   (nd[k+1])
      );
      assign stage_vld[NF+k] = nv[k+1];
    end
  endgenerate

  assign nr[NN]    = out_ready;
  assign out_valid = nv[NN];
  assign out_p     = nd[NN][PW-1:0];
  assign out_trunc = nd[NN][NW-1 -: TW];
  assign busy      = |stage_vld;

endmodule
